// File: rtl/seg7_scan_ctrl_pkg.sv
// seg7_defs: shared constants for the seven-segment scan controller.
//   SEG_OFF / AN_OFF : all-dark bus values (active-low)
//   HEX_0..HEX_F     : active-low {a,b,c,d,e,f,g} patterns, bit6 = a
//   state_t          : scan FSM encodings
//   lz_dark()        : leading-zero test used when SEG7_LZ_SUPPRESS_EN is defined
package seg7_defs;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  localparam logic [6:0] HEX_0 = 7'b0000001;
  localparam logic [6:0] HEX_1 = 7'b1001111;
  localparam logic [6:0] HEX_2 = 7'b0010010;
  localparam logic [6:0] HEX_3 = 7'b0000110;
  localparam logic [6:0] HEX_4 = 7'b1001100;
  localparam logic [6:0] HEX_5 = 7'b0100100;
  localparam logic [6:0] HEX_6 = 7'b0100000;
  localparam logic [6:0] HEX_7 = 7'b0001111;
  localparam logic [6:0] HEX_8 = 7'b0000000;
  localparam logic [6:0] HEX_9 = 7'b0000100;
  localparam logic [6:0] HEX_A = 7'b0001000;
  localparam logic [6:0] HEX_B = 7'b1100000;
  localparam logic [6:0] HEX_C = 7'b0110001;
  localparam logic [6:0] HEX_D = 7'b1000010;
  localparam logic [6:0] HEX_E = 7'b0110000;
  localparam logic [6:0] HEX_F = 7'b0111000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  // Digit i>0 is a leading zero when its nibble and every higher nibble are
  // zero; a lit decimal point on that digit keeps it visible.
  function automatic logic lz_dark(input logic [15:0] v, input logic [3:0] dpv,
                                   input logic [1:0] i);
    logic hi_zero;
    case (i)
      2'd0:    hi_zero = 1'b0;
      2'd1:    hi_zero = (v[15:4] == 12'h000);
      2'd2:    hi_zero = (v[15:8] == 8'h00);
      default: hi_zero = (v[15:12] == 4'h0);
    endcase
    return hi_zero & ~dpv[i];
  endfunction
endpackage

// File: rtl/seg7_scan_ctrl_hex_to_seg7.sv
// hex_to_seg7: combinational 4-bit hex -> active-low seven-segment decoder.
//   nib : hex digit
//   seg : {a,b,c,d,e,f,g}, bit6 = a, 0 = segment lit
module hex_to_seg7
  import seg7_defs::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = HEX_0;
      4'h1: seg = HEX_1;
      4'h2: seg = HEX_2;
      4'h3: seg = HEX_3;
      4'h4: seg = HEX_4;
      4'h5: seg = HEX_5;
      4'h6: seg = HEX_6;
      4'h7: seg = HEX_7;
      4'h8: seg = HEX_8;
      4'h9: seg = HEX_9;
      4'hA: seg = HEX_A;
      4'hB: seg = HEX_B;
      4'hC: seg = HEX_C;
      4'hD: seg = HEX_D;
      4'hE: seg = HEX_E;
      default: seg = HEX_F;
    endcase
  end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexes four hex digits onto a shared active-low
// seven-segment bus with anti-ghosting blank intervals at each slot start.
// Inputs are latched once per frame (on entry to the digit-0 slot).
//   clk, rst      : clock, async active-low reset
//   en            : display enable (0 -> IDLE, outputs dark)
//   value         : four hex nibbles, digit i = value[4i+3:4i]
//   dp_in         : decimal point request per digit (1 = lit)
//   blank_mask    : 1 = digit forced dark (slot still consumed)
//   an            : active-low anodes, one-hot-low when driving
//   seg7          : active-low segments {a..g}
//   dp            : active-low decimal point
//   frame_start   : one-cycle pulse on entry to the digit-0 slot
// Optional: define SEG7_LZ_SUPPRESS_EN for leading-zero suppression.
module seg7_scan_ctrl
  import seg7_defs::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg7,
  output logic        dp,
  output logic        frame_start
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] B_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  // With no blank interval every slot starts directly in DRIVE.
  localparam state_t FIRST = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;      // position within the current slot
  logic [1:0]    idx, idx_n;
  logic [15:0]   val_lat, val_n;
  logic [3:0]    dp_lat, dpl_n, mask_lat, msk_n;
  logic          latch;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    latch   = 1'b0;
    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          state_n = FIRST;
          cnt_n   = '0;
          idx_n   = 2'd0;
          latch   = 1'b1;
        end
        BLANK: begin
          cnt_n = cnt + 1'b1;
          if (cnt == B_LAST) state_n = DRIVE;
        end
        DRIVE: begin
          if (cnt == LAST) begin
            state_n = FIRST;
            cnt_n   = '0;
            idx_n   = idx + 2'd1;
            latch   = (idx == 2'd3);
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    val_n = latch ? value      : val_lat;
    dpl_n = latch ? dp_in      : dp_lat;
    msk_n = latch ? blank_mask : mask_lat;
  end

  // Outputs are computed from the next-state view so they change on the
  // same edge that enters the phase.
  logic [3:0] nib;
  logic [6:0] seg_dec;
  logic       lit;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  assign nib = val_n[{idx_n, 2'b00} +: 4];

  hex_to_seg7 u_dec (.nib(nib), .seg(seg_dec));

  always_comb begin
    lit = (state_n == DRIVE) & ~msk_n[idx_n];
`ifdef SEG7_LZ_SUPPRESS_EN
    lit = lit & ~lz_dark(val_n, dpl_n, idx_n);
`endif
    an_n  = lit ? ~(4'b0001 << idx_n) : AN_OFF;
    seg_n = lit ? seg_dec : SEG_OFF;
    dp_n  = lit ? ~dpl_n[idx_n] : 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= 2'd0;
      val_lat     <= 16'h0000;
      dp_lat      <= 4'h0;
      mask_lat    <= 4'h0;
      an          <= AN_OFF;
      seg7        <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      val_lat     <= val_n;
      dp_lat      <= dpl_n;
      mask_lat    <= msk_n;
      an          <= an_n;
      seg7        <= seg_n;
      dp          <= dp_n;
      frame_start <= latch;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed bench, SCAN_DIV=8, BLANK_CYCLES=2.
// fc tracks the frame-relative cycle (0 = cycle after the frame_start edge).
module tb_seg7_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic [3:0]  an;
  logic [6:0]  seg7;
  logic        dp;
  logic        frame_start;

  int tests = 0;
  int fails = 0;
  int fc    = 0;

  localparam logic [3:0] AOFF = 4'b1111;
  localparam logic [6:0] SOFF = 7'b1111111;

  seg7_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .value(value), .dp_in(dp_in),
    .blank_mask(blank_mask), .an(an), .seg7(seg7), .dp(dp),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    fc = (fc + 1) % 32;
  endtask

  task automatic go(input int k);
    while (fc != k) tick();
  endtask

  task automatic chk(input string tag, input logic [3:0] a, input logic [6:0] s,
                     input logic d, input logic f);
    logic [12:0] obs, exp;
    obs = {an, seg7, dp, frame_start};
    exp = {a, s, d, f};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed an=%b seg7=%b dp=%b fs=%b, expected an=%b seg7=%b dp=%b fs=%b",
             tag, an, seg7, dp, frame_start, a, s, d, f);
    end
  endtask

  initial begin
    int n;
    rst = 1'b0; en = 1'b1; value = 16'h1234; dp_in = 4'h0; blank_mask = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", AOFF, SOFF, 1'b1, 1'b0);

    // First frame after reset release
    rst = 1'b1;
    tick(); fc = 0;
    chk("fs_first", AOFF, SOFF, 1'b1, 1'b1);
    go(1);  chk("blank_d0", AOFF, SOFF, 1'b1, 1'b0);
    go(2);  chk("d0_4", 4'b1110, 7'b1001100, 1'b1, 1'b0);
    go(7);  chk("d0_4_end", 4'b1110, 7'b1001100, 1'b1, 1'b0);
    go(8);  chk("blank_d1", AOFF, SOFF, 1'b1, 1'b0);
    go(10); chk("d1_3", 4'b1101, 7'b0000110, 1'b1, 1'b0);

    // New inputs mid-frame: old value stays until next frame start
    value = 16'hABCD; dp_in = 4'b0001;
    go(18); chk("d2_old", 4'b1011, 7'b0010010, 1'b1, 1'b0);
    go(26); chk("d3_old", 4'b0111, 7'b1001111, 1'b1, 1'b0);
    go(0);  chk("fs_frame2", AOFF, SOFF, 1'b1, 1'b1);
    go(2);  chk("d0_d_dp", 4'b1110, 7'b1000010, 1'b0, 1'b0);
    go(8);  chk("blank_dp_off", AOFF, SOFF, 1'b1, 1'b0);
    go(10); chk("d1_C", 4'b1101, 7'b0110001, 1'b1, 1'b0);
    go(18); chk("d2_b", 4'b1011, 7'b1100000, 1'b1, 1'b0);
    go(26); chk("d3_A", 4'b0111, 7'b0001000, 1'b1, 1'b0);

    // Frame period between frame_start pulses
    go(0);
    n = 0;
    do begin tick(); n++; end while (!frame_start && n < 100);
    tests++;
    assert (n == 32) else begin
      fails++;
      $error("FAIL fs_period: observed %0d cycles, expected 32", n);
    end
    fc = 0;

    // Change to FFFF during the digit-2 slot
    go(16); value = 16'hFFFF; dp_in = 4'h0;
    go(18); chk("d2_hold_b", 4'b1011, 7'b1100000, 1'b1, 1'b0);
    go(26); chk("d3_hold_A", 4'b0111, 7'b0001000, 1'b1, 1'b0);
    go(2);  chk("d0_F", 4'b1110, 7'b0111000, 1'b1, 1'b0);
    go(26); chk("d3_F", 4'b0111, 7'b0111000, 1'b1, 1'b0);

    // Digit 2 masked in the following frame
    blank_mask = 4'b0100;
    go(18); chk("mask_d2_start", AOFF, SOFF, 1'b1, 1'b0);
    go(23); chk("mask_d2_end", AOFF, SOFF, 1'b1, 1'b0);
    go(25); chk("mask_d3_blank", AOFF, SOFF, 1'b1, 1'b0);
    go(26); chk("mask_d3_on", 4'b0111, 7'b0111000, 1'b1, 1'b0);
    blank_mask = 4'h0;

    // Enable dropped mid digit-1 drive
    go(10); chk("pre_en_drop", 4'b1101, 7'b0111000, 1'b1, 1'b0);
    en = 1'b0;
    tick(); chk("en_drop", AOFF, SOFF, 1'b1, 1'b0);
    tick(); tick(); chk("en_idle", AOFF, SOFF, 1'b1, 1'b0);
    en = 1'b1;
    tick(); fc = 0;
    chk("en_restart_fs", AOFF, SOFF, 1'b1, 1'b1);
    go(1);  chk("en_restart_blank", AOFF, SOFF, 1'b1, 1'b0);
    go(2);  chk("en_restart_d0", 4'b1110, 7'b0111000, 1'b1, 1'b0);

    // Asynchronous reset mid-slot, no clock edge in between
    go(12); chk("pre_async", 4'b1101, 7'b0111000, 1'b1, 1'b0);
    rst = 1'b0;
    #2;
    chk("async_rst", AOFF, SOFF, 1'b1, 1'b0);

    // Leading zeros: 0x0040
    value = 16'h0040; dp_in = 4'h0;
    rst = 1'b1;
    tick(); fc = 0;
    chk("lz_fs", AOFF, SOFF, 1'b1, 1'b1);
    go(2);  chk("lz_d0", 4'b1110, 7'b0000001, 1'b1, 1'b0);
    go(10); chk("lz_d1", 4'b1101, 7'b1001100, 1'b1, 1'b0);
`ifdef SEG7_LZ_SUPPRESS_EN
    go(18); chk("lz_d2", AOFF, SOFF, 1'b1, 1'b0);
    go(26); chk("lz_d3", AOFF, SOFF, 1'b1, 1'b0);
`else
    go(18); chk("lz_d2", 4'b1011, 7'b0000001, 1'b1, 1'b0);
    go(26); chk("lz_d3", 4'b0111, 7'b0000001, 1'b1, 1'b0);
`endif
    value = 16'h0000;
    go(2);  chk("zero_d0", 4'b1110, 7'b0000001, 1'b1, 1'b0);
`ifdef SEG7_LZ_SUPPRESS_EN
    go(10); chk("zero_d1", AOFF, SOFF, 1'b1, 1'b0);
`else
    go(10); chk("zero_d1", 4'b1101, 7'b0000001, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
